// File: rtl/stat_pkg.sv
// Shared constants for the statistics frame controller: colour and CFA
// codes, FSM state encoding, gain format and the Bayer site classifier.
package stat_pkg;

   localparam int MAX_LOG2_SUM = 22;
   localparam int FIN_TIMEOUT  = 64;
   localparam int GAIN_W       = 10;
   localparam int FRAC_W       = 8;    // U2.8 gain fraction bits

   localparam logic [1:0] COL_R = 2'd0;
   localparam logic [1:0] COL_G = 2'd1;
   localparam logic [1:0] COL_B = 2'd2;

   localparam logic [1:0] CFA_RGGB = 2'd0;
   localparam logic [1:0] CFA_GRBG = 2'd1;
   localparam logic [1:0] CFA_GBRG = 2'd2;
   localparam logic [1:0] CFA_BGGR = 2'd3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_STREAM   = 3'd1;
   localparam logic [2:0] ST_WAIT_FIN = 3'd2;
   localparam logic [2:0] ST_DIV_R    = 3'd3;
   localparam logic [2:0] ST_DIV_B    = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   // Quad position already rotated into RGGB space: 0 R, 1 G (R row),
   // 2 G (B row), 3 B.
   function automatic logic [1:0] site_color(input logic [1:0] p);
      logic [1:0] c;
      c = COL_G;
      if (p == 2'd0) c = COL_R;
      if (p == 2'd3) c = COL_B;
      return c;
   endfunction

endpackage

// File: rtl/stat_frame_ctrl_seq_div.sv
// Restoring divider, one quotient bit per cycle. Quotients that would not
// fit in QW bits (including divide by zero) saturate without iterating.
module seq_div #(
   parameter int QW = stat_pkg::GAIN_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [15:0]   i_num,
   input  logic [7:0]    i_den,
   output logic          o_done,
   output logic [QW-1:0] o_quo
);
   import stat_pkg::*;

   logic [7:0]    r_den;
   logic [7:0]    r_rem;
   logic [QW-1:0] r_num_lo;
   logic [QW-1:0] r_q;
   logic [4:0]    r_cnt;
   logic          r_busy;
   logic          r_done;

   logic [8:0]    w_trial;
   logic          w_ge;
   logic [15:0]   w_num_hi;
   logic          w_sat;

   assign w_trial  = {r_rem, r_num_lo[QW-1]};
   assign w_ge     = w_trial >= {1'b0, r_den};
   // Bits above the quotient width go straight into the partial remainder;
   // if that already reaches the divisor the quotient overflows.
   assign w_num_hi = i_num >> QW;
   assign w_sat    = (i_den == 8'd0) || (w_num_hi >= {8'd0, i_den});

   assign o_done = r_done;
   assign o_quo  = r_q;

   // Latch operands on start, then shift in one numerator bit per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_den    <= '0;
         r_rem    <= '0;
         r_num_lo <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_den <= i_den;
            r_cnt <= '0;
            if (w_sat) begin
               r_q    <= '1;
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_rem    <= w_num_hi[7:0];
               r_num_lo <= i_num[QW-1:0];
               r_q      <= '0;
               r_busy   <= 1'b1;
            end
         end else if (r_busy) begin
            r_rem    <= w_ge ? 8'(w_trial - {1'b0, r_den}) : w_trial[7:0];
            r_num_lo <= r_num_lo << 1;
            r_q      <= {r_q[QW-2:0], w_ge};
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == 5'(QW - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/stat_frame_ctrl.sv
// Frame sequencer: subsamples a Bayer raster into one R/G/B per quad for the
// mean accumulator, waits for its finish, then derives gray-world R/B gains.
module stat_frame_ctrl #(
   parameter int MAX_LOG2_SUM = stat_pkg::MAX_LOG2_SUM,
   parameter int FIN_TIMEOUT  = stat_pkg::FIN_TIMEOUT,
   parameter int GAIN_W       = stat_pkg::GAIN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [3:0]        log2_w_i,
   input  logic [3:0]        log2_h_i,
   input  logic [1:0]        cfa_i,
   input  logic              pix_valid_i,
   input  logic [7:0]        pix_value_i,
   output logic              pix_ready_o,
   output logic              stat_clr_o,
   output logic              stat_valid_o,
   output logic [1:0]        stat_color_o,
   output logic [7:0]        stat_value_o,
   output logic              stat_last_o,
   output logic [4:0]        stat_size_o,
   input  logic              stat_finish_i,
   input  logic [7:0]        r_mean_i,
   input  logic [7:0]        g_mean_i,
   input  logic [7:0]        b_mean_i,
   output logic [GAIN_W-1:0] gain_r_o,
   output logic [GAIN_W-1:0] gain_b_o,
   output logic              gains_valid_o,
   output logic              busy_o,
   output logic              err_o
);
   import stat_pkg::*;

   localparam int TW = $clog2(FIN_TIMEOUT + 1);

   logic [2:0]        r_state;
   logic [3:0]        r_lw, r_lh;
   logic [1:0]        r_cfa;
   logic [15:0]       r_col, r_row;
   logic [4:0]        r_size;
   logic              r_err;
   logic [TW-1:0]     r_tmo;
   logic [7:0]        r_rm, r_gm, r_bm;
   logic [GAIN_W-1:0] r_qr, r_gr, r_gb;
   logic              r_div_go;
   logic              r_sv, r_slast;
   logic [1:0]        r_scol;
   logic [7:0]        r_sval;

   logic [4:0]        w_sum;
   logic              w_legal, w_idle, w_accept, w_xfer, w_fwd, w_near_end, w_frame_end;
   logic [15:0]       w_col_max, w_row_max;
   logic [1:0]        w_phase, w_color;
   logic              w_div_done;
   logic [GAIN_W-1:0] w_quo;
   logic [15:0]       w_num;
   logic [7:0]        w_den;

   assign w_sum    = {1'b0, log2_w_i} + {1'b0, log2_h_i};
   assign w_legal  = (log2_w_i != 4'd0) && (log2_h_i != 4'd0) && (w_sum <= 5'(MAX_LOG2_SUM));
   assign w_idle   = r_state == ST_IDLE;
   assign w_accept = start_i && w_idle && w_legal;
   assign w_xfer   = pix_valid_i && pix_ready_o;

   assign w_col_max   = 16'((32'd1 << r_lw) - 32'd1);
   assign w_row_max   = 16'((32'd1 << r_lh) - 32'd1);
   // Rotating the quad position by the CFA phase maps every pattern onto RGGB.
   assign w_phase     = {r_row[0], r_col[0]} ^ r_cfa;
   assign w_color     = site_color(w_phase);
   assign w_fwd       = w_phase != 2'd2;
   assign w_near_end  = (r_row >= w_row_max - 16'd1) && (r_col >= w_col_max - 16'd1);
   assign w_frame_end = w_xfer && (r_row == w_row_max) && (r_col == w_col_max);

   assign w_num = 16'(r_gm) << FRAC_W;
   assign w_den = (r_state == ST_DIV_B) ? r_bm : r_rm;

   assign pix_ready_o   = r_state == ST_STREAM;
   assign stat_clr_o    = w_accept;
   assign busy_o        = !w_idle;
   assign gains_valid_o = r_state == ST_DONE;
   assign err_o         = r_err;
   assign stat_size_o   = r_size;
   assign stat_valid_o  = r_sv;
   assign stat_color_o  = r_scol;
   assign stat_value_o  = r_sval;
   assign stat_last_o   = r_slast;
   assign gain_r_o      = r_gr;
   assign gain_b_o      = r_gb;

   seq_div #(.QW(GAIN_W)) u_div (
      .clk     (clk),
      .rst     (rst),
      .i_start (r_div_go),
      .i_num   (w_num),
      .i_den   (w_den),
      .o_done  (w_div_done),
      .o_quo   (w_quo)
   );

   // Frame FSM: config latch, raster counters, finish timeout, R then B divide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_lw     <= '0;
         r_lh     <= '0;
         r_cfa    <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_size   <= '0;
         r_err    <= 1'b0;
         r_tmo    <= '0;
         r_rm     <= '0;
         r_gm     <= '0;
         r_bm     <= '0;
         r_qr     <= '0;
         r_gr     <= '0;
         r_gb     <= '0;
         r_div_go <= 1'b0;
      end else begin
         r_div_go <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  if (w_legal) begin
                     r_lw    <= log2_w_i;
                     r_lh    <= log2_h_i;
                     r_cfa   <= cfa_i;
                     r_size  <= w_sum - 5'd2;
                     r_col   <= '0;
                     r_row   <= '0;
                     r_err   <= 1'b0;
                     r_state <= ST_STREAM;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (w_xfer) begin
                  if (r_col == w_col_max) begin
                     r_col <= '0;
                     r_row <= r_row + 16'd1;
                  end else begin
                     r_col <= r_col + 16'd1;
                  end
                  if (w_frame_end) begin
                     r_tmo   <= '0;
                     r_state <= ST_WAIT_FIN;
                  end
               end
            end
            ST_WAIT_FIN: begin
               if (stat_finish_i) begin
                  r_rm     <= r_mean_i;
                  r_gm     <= g_mean_i;
                  r_bm     <= b_mean_i;
                  r_div_go <= 1'b1;
                  r_state  <= ST_DIV_R;
               end else if (r_tmo == TW'(FIN_TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            ST_DIV_R: begin
               if (w_div_done) begin
                  r_qr     <= w_quo;
                  r_div_go <= 1'b1;
                  r_state  <= ST_DIV_B;
               end
            end
            ST_DIV_B: begin
               if (w_div_done) begin
                  r_gr    <= r_qr;
                  r_gb    <= w_quo;
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Registered forward of kept quad samples to the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sv    <= 1'b0;
         r_slast <= 1'b0;
         r_scol  <= '0;
         r_sval  <= '0;
      end else begin
         r_sv    <= w_xfer && w_fwd;
         r_slast <= w_xfer && w_fwd && w_near_end;
         if (w_xfer && w_fwd) begin
            r_scol <= w_color;
            r_sval <= pix_value_i;
         end
      end
   end

endmodule

// File: tb/tb_stat_frame_ctrl.sv
// Randomised self-checking bench: a Bayer/quad reference model predicts the
// forwarded stream and an arithmetic model predicts the gains.
module tb_stat_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [3:0] log2_w_i, log2_h_i;
   logic [1:0] cfa_i;
   logic       pix_valid_i;
   logic [7:0] pix_value_i;
   logic       pix_ready_o, stat_clr_o, stat_valid_o, stat_last_o;
   logic [1:0] stat_color_o;
   logic [7:0] stat_value_o;
   logic [4:0] stat_size_o;
   logic       stat_finish_i;
   logic [7:0] r_mean_i, g_mean_i, b_mean_i;
   logic [9:0] gain_r_o, gain_b_o;
   logic       gains_valid_o, busy_o, err_o;

   always #5 clk = ~clk;

   stat_frame_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start_i), .log2_w_i(log2_w_i), .log2_h_i(log2_h_i),
      .cfa_i(cfa_i), .pix_valid_i(pix_valid_i), .pix_value_i(pix_value_i),
      .pix_ready_o(pix_ready_o), .stat_clr_o(stat_clr_o), .stat_valid_o(stat_valid_o),
      .stat_color_o(stat_color_o), .stat_value_o(stat_value_o), .stat_last_o(stat_last_o),
      .stat_size_o(stat_size_o), .stat_finish_i(stat_finish_i), .r_mean_i(r_mean_i),
      .g_mean_i(g_mean_i), .b_mean_i(b_mean_i), .gain_r_o(gain_r_o), .gain_b_o(gain_b_o),
      .gains_valid_o(gains_valid_o), .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct {int col; int val; bit last;} beat_t;

   int    total = 0, bad = 0;
   int    clr_cnt, gv_cnt, last_cnt, beats;
   int    exp_gr = 0, exp_gb = 0;
   int    img[$];
   beat_t q[$];
   beat_t mb;
   // Bayer site colour per CFA, indexed by (y%2)*2 + x%2; 0 R, 1 G, 2 B.
   int    bayer[4][4] = '{'{0,1,1,2}, '{1,0,2,1}, '{1,2,0,1}, '{2,1,1,0}};

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int gain(input int g, input int d);
      int v;
      if (d == 0) return 1023;
      v = (g * 256) / d;
      return (v > 1023) ? 1023 : v;
   endfunction

   // Expected forwarded stream: every R and B site, plus the G sharing a row
   // with R; each colour's final sample carries last.
   task automatic build(input int lw, input int lh, input int cfa, input bit pat);
      int w, h, c, v;
      int lastidx[3];
      bit rowr;
      beat_t b;
      w = 1 << lw;
      h = 1 << lh;
      img.delete();
      q.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            c = bayer[cfa][(y % 2) * 2 + (x % 2)];
            v = pat ? ((c == 0) ? 100 : (c == 1) ? 50 : 200) : int'($urandom_range(0, 255));
            img.push_back(v);
            rowr = (bayer[cfa][(y % 2) * 2] == 0) || (bayer[cfa][(y % 2) * 2 + 1] == 0);
            if (c != 1 || rowr) begin
               b.col = c; b.val = v; b.last = 1'b0;
               q.push_back(b);
            end
         end
      for (int i = 0; i < q.size(); i++) lastidx[q[i].col] = i;
      for (int k = 0; k < 3; k++) q[lastidx[k]].last = 1'b1;
   endtask

   // Stream monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (stat_clr_o) clr_cnt++;
         if (gains_valid_o) gv_cnt++;
         if (stat_last_o) last_cnt++;
         if (stat_valid_o) begin
            beats++;
            if (q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               mb = q.pop_front();
               chk("color", int'(stat_color_o), mb.col);
               chk("value", int'(stat_value_o), mb.val);
               chk("last", int'(stat_last_o), int'(mb.last));
            end
         end
      end
   end

   // Drive n raster pixels; called and returns #1 after a rising edge.
   task automatic send(input int n, input bit gaps, input bit mid);
      int idx = 0, guard = 0;
      bit rdy;
      while (idx < n && guard < 3000) begin
         rdy           = pix_ready_o;
         pix_valid_i   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         pix_value_i   = 8'(img[idx]);
         start_i       = mid && (idx == n / 2);
         stat_finish_i = mid && (idx == 1);
         @(posedge clk);
         guard++;
         if (pix_valid_i && rdy) idx++;
         #1;
      end
      pix_valid_i = 1'b0; start_i = 1'b0; stat_finish_i = 1'b0;
      if (idx < n) chk("send_timeout", idx, n);
   endtask

   task automatic run_frame(input int lw, input int lh, input int cfa, input bit gaps,
                            input bit pat, input bit mid, input bit fin,
                            input int rm, input int gm, input int bm);
      int n, k;
      n = (1 << lw) * (1 << lh);
      build(lw, lh, cfa, pat);
      clr_cnt = 0; gv_cnt = 0; last_cnt = 0; beats = 0;
      log2_w_i = 4'(lw); log2_h_i = 4'(lh); cfa_i = 2'(cfa); start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      chk("clr_pulse", clr_cnt, 1);
      chk("busy_start", int'(busy_o), 1);
      chk("err_cleared", int'(err_o), 0);
      chk("size", int'(stat_size_o), lw + lh - 2);
      if (mid) begin
         log2_w_i = 4'd0;
         r_mean_i = 8'd7; g_mean_i = 8'd7; b_mean_i = 8'd7;
      end
      send(n, gaps, mid);
      chk("ready_drop", int'(pix_ready_o), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("beats", beats, n * 3 / 4);
      chk("q_empty", q.size(), 0);
      chk("last_cnt", last_cnt, 3);
      chk("size_hold", int'(stat_size_o), lw + lh - 2);
      chk("err_mid", int'(err_o), 0);
      r_mean_i = 8'(rm); g_mean_i = 8'(gm); b_mean_i = 8'(bm);
      stat_finish_i = fin;
      @(posedge clk); #1 stat_finish_i = 1'b0;
      k = 0;
      if (fin) begin
         while (!gains_valid_o && k < 100) begin @(posedge clk); #1 k++; end
         chk("gv_seen", int'(gains_valid_o), 1);
         exp_gr = gain(gm, rm);
         exp_gb = gain(gm, bm);
         @(posedge clk); #1;
         chk("gain_r", int'(gain_r_o), exp_gr);
         chk("gain_b", int'(gain_b_o), exp_gb);
         chk("gv_once", gv_cnt, 1);
         chk("idle_after", int'(busy_o), 0);
      end else begin
         while (busy_o && k < 200) begin @(posedge clk); #1 k++; end
         chk("tmo_idle", int'(busy_o), 0);
         chk("tmo_len", int'(k >= 58 && k <= 66), 1);
         chk("tmo_err", int'(err_o), 1);
         chk("tmo_gain_r", int'(gain_r_o), exp_gr);
         chk("tmo_gain_b", int'(gain_b_o), exp_gb);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, int'(stat_valid_o), 0);
      chk({tag, "_last"}, int'(stat_last_o), 0);
      chk({tag, "_ready"}, int'(pix_ready_o), 0);
      chk({tag, "_clr"}, int'(stat_clr_o), 0);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_err"}, int'(err_o), 0);
      chk({tag, "_size"}, int'(stat_size_o), 0);
      chk({tag, "_gr"}, int'(gain_r_o), 0);
      chk({tag, "_gb"}, int'(gain_b_o), 0);
      chk({tag, "_gv"}, int'(gains_valid_o), 0);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; log2_w_i = '0; log2_h_i = '0; cfa_i = '0;
      pix_valid_i = 1'b0; pix_value_i = '0; stat_finish_i = 1'b0;
      r_mean_i = '0; g_mean_i = '0; b_mean_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_zero("reset");

      // 4x4 RGGB, flat colours
      run_frame(2, 2, 0, 1'b0, 1'b1, 1'b0, 1'b1, 100, 50, 200);
      // GBRG with gaps, stray start and finish mid-stream
      run_frame(2, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1, 100, 50, 200);
      // saturation: zero divisor and overflow
      run_frame(2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 255, 1);
      // finish withheld
      run_frame(2, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 10, 10, 10);

      // illegal configurations
      clr_cnt = 0;
      log2_w_i = 4'd12; log2_h_i = 4'd11; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      chk("ill_err", int'(err_o), 1);
      chk("ill_busy", int'(busy_o), 0);
      log2_w_i = 4'd0; log2_h_i = 4'd3; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      @(posedge clk); #1;
      chk("ill_busy2", int'(busy_o), 0);
      chk("ill_clr", clr_cnt, 0);
      // legal start clears the error
      run_frame(2, 1, 3, 1'b1, 1'b0, 1'b0, 1'b1, 80, 120, 160);

      // reset mid-stream
      build(2, 2, 0, 1'b0);
      log2_w_i = 4'd2; log2_h_i = 4'd2; cfa_i = 2'd0; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      send(5, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      q.delete();
      chk_zero("midrst");
      exp_gr = 0; exp_gb = 0;
      run_frame(1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 64, 32, 16);

      // random frames
      for (int i = 0; i < 6; i++) begin
         run_frame(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 1'b1,
                   ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
